// File: rtl/hazard_fwd_ctrl.sv
`default_nettype none
//==============================================================================
//  Module   : hazard_fwd_ctrl
//  Purpose  : Hazard detection and operand-forwarding control for a classic
//             5-stage in-order pipeline. It keeps a small shadow copy of the
//             destination info of the instructions in EX, MEM and WB, and
//             derives stall, bubble and flush controls plus the registered
//             ALU operand-forwarding selects.
//  Revision : 1.0  initial release
//------------------------------------------------------------------------------
//  Build option (macro FORWARDING_EN):
//    defined   : EX/MEM forwarding enabled; only load-use costs one stall.
//    undefined : no forwarding; forward selects are constant 00 and any RAW
//                dependency on EX (2 cycles) or MEM (1 cycle) stalls.
//------------------------------------------------------------------------------
//  Ports
//    clk          in   single clock, rising edge
//    rst_n        in   asynchronous active-low reset
//    id_valid     in   instruction in ID is real
//    id_rs1/rs2   in   ID source register indices      [REG_AW-1:0]
//    id_use_rs1/2 in   the corresponding source is read
//    id_rd        in   ID destination index             [REG_AW-1:0]
//    id_regwrite  in   ID instruction writes rd
//    id_memread   in   ID instruction is a load
//    ex_flush     in   taken branch/jump resolved in EX
//    mem_wait     in   data memory busy, whole pipeline freezes
//    forward_A/B  out  operand select: 00 regfile, 01 mem_result, 10 alu_result
//    stall        out  hold PC and IF/ID
//    id_ex_bubble out  load a NOP into ID/EX
//    if_id_flush  out  squash IF/ID contents
//==============================================================================
module hazard_fwd_ctrl #(
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              ex_flush,
    input  logic              mem_wait,
    output logic [1:0]        forward_A,
    output logic [1:0]        forward_B,
    output logic              stall,
    output logic              id_ex_bubble,
    output logic              if_id_flush
);

    //--------------------------------------------------------------------------
    // Constants
    //--------------------------------------------------------------------------
    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_LU_STALL = 2'd1;
    localparam logic [1:0] ST_FREEZE   = 2'd2;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_MEM  = 2'b01;
    localparam logic [1:0] SEL_ALU  = 2'b10;

    //--------------------------------------------------------------------------
    // Shadow pipeline slots
    //--------------------------------------------------------------------------
    logic              r_ex_valid;
    logic [REG_AW-1:0] r_ex_rd;
    logic              r_ex_regwrite;
    logic              r_ex_memread;

    logic              r_mem_valid;
    logic [REG_AW-1:0] r_mem_rd;
    logic              r_mem_regwrite;
    logic              r_mem_memread;

    logic              r_wb_valid;
    logic [REG_AW-1:0] r_wb_rd;
    logic              r_wb_regwrite;
    logic              r_wb_memread;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;

    logic [1:0]        r_fwd_a;
    logic [1:0]        r_fwd_b;

    //--------------------------------------------------------------------------
    // Source matching
    //--------------------------------------------------------------------------
    logic w_ex_src;
    logic w_mem_src;
    logic w_rs1_ex;
    logic w_rs2_ex;
    logic w_rs1_mem;
    logic w_rs2_mem;

    // A slot can supply a result only if it really writes a non-zero register.
    assign w_ex_src  = r_ex_valid  & r_ex_regwrite  & (r_ex_rd  != '0);
    assign w_mem_src = r_mem_valid & r_mem_regwrite & (r_mem_rd != '0);

    assign w_rs1_ex  = id_valid & id_use_rs1 & w_ex_src  & (id_rs1 == r_ex_rd);
    assign w_rs2_ex  = id_valid & id_use_rs2 & w_ex_src  & (id_rs2 == r_ex_rd);
    assign w_rs1_mem = id_valid & id_use_rs1 & w_mem_src & (id_rs1 == r_mem_rd);
    assign w_rs2_mem = id_valid & id_use_rs2 & w_mem_src & (id_rs2 == r_mem_rd);

    logic       w_hazard;
    logic [1:0] w_sel_a;
    logic [1:0] w_sel_b;

`ifdef FORWARDING_EN
    logic w_ex_load;
    logic w_lu_rs1;
    logic w_lu_rs2;

    // Load-use only depends on the load being valid and targeting a real
    // register; its regwrite flag is not consulted.
    assign w_ex_load = r_ex_valid & r_ex_memread & (r_ex_rd != '0);
    assign w_lu_rs1  = id_valid & id_use_rs1 & w_ex_load & (id_rs1 == r_ex_rd);
    assign w_lu_rs2  = id_valid & id_use_rs2 & w_ex_load & (id_rs2 == r_ex_rd);

    // After one stall cycle the load has moved to MEM and is forwarded from
    // there, so LU_STALL never requests a second bubble.
    assign w_hazard = (w_lu_rs1 | w_lu_rs2) & (r_state != ST_LU_STALL);

    // EX (youngest producer) wins over MEM.
    assign w_sel_a = w_rs1_ex ? SEL_ALU : (w_rs1_mem ? SEL_MEM : SEL_NONE);
    assign w_sel_b = w_rs2_ex ? SEL_ALU : (w_rs2_mem ? SEL_MEM : SEL_NONE);
`else
    // Without forwarding the consumer waits until the producer reaches WB,
    // where the register file makes the value visible to ID.
    assign w_hazard = w_rs1_ex | w_rs2_ex | w_rs1_mem | w_rs2_mem;
    assign w_sel_a  = SEL_NONE;
    assign w_sel_b  = SEL_NONE;

    logic w_unused_state;
    assign w_unused_state = &{1'b0, r_state};
`endif

    // WB contents are tracked for completeness of the shadow pipeline but no
    // decision depends on them.
    logic w_unused_wb;
    assign w_unused_wb = &{1'b0, r_wb_valid, r_wb_rd, r_wb_regwrite, r_wb_memread};

    //--------------------------------------------------------------------------
    // Control decode: mem_wait > ex_flush > load-use / RAW hazard
    //--------------------------------------------------------------------------
    logic w_advance;
    logic w_flush;
    logic w_lu_bubble;
    logic w_insert_nop;

    always_comb begin
        w_advance    = ~mem_wait;
        w_flush      = ~mem_wait & ex_flush;
        w_lu_bubble  = ~mem_wait & ~ex_flush & w_hazard;
        w_insert_nop = w_flush | w_lu_bubble;

        w_state_nxt = ST_RUN;
        if (mem_wait) begin
            w_state_nxt = ST_FREEZE;
        end else if (w_lu_bubble) begin
            w_state_nxt = ST_LU_STALL;
        end
    end

    // Outputs are forced low while reset is asserted, even if mem_wait or
    // ex_flush are driven at that time.
    assign stall        = rst_n & (mem_wait | w_lu_bubble);
    assign id_ex_bubble = rst_n & w_insert_nop;
    assign if_id_flush  = rst_n & w_flush;

    assign forward_A = r_fwd_a;
    assign forward_B = r_fwd_b;

    //--------------------------------------------------------------------------
    // State register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    //--------------------------------------------------------------------------
    // Slot advance and forward-select registers. Everything holds while the
    // pipeline is frozen.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid     <= 1'b0;
            r_ex_rd        <= '0;
            r_ex_regwrite  <= 1'b0;
            r_ex_memread   <= 1'b0;
            r_mem_valid    <= 1'b0;
            r_mem_rd       <= '0;
            r_mem_regwrite <= 1'b0;
            r_mem_memread  <= 1'b0;
            r_wb_valid     <= 1'b0;
            r_wb_rd        <= '0;
            r_wb_regwrite  <= 1'b0;
            r_wb_memread   <= 1'b0;
            r_fwd_a        <= SEL_NONE;
            r_fwd_b        <= SEL_NONE;
        end else if (w_advance) begin
            r_wb_valid     <= r_mem_valid;
            r_wb_rd        <= r_mem_rd;
            r_wb_regwrite  <= r_mem_regwrite;
            r_wb_memread   <= r_mem_memread;
            r_mem_valid    <= r_ex_valid;
            r_mem_rd       <= r_ex_rd;
            r_mem_regwrite <= r_ex_regwrite;
            r_mem_memread  <= r_ex_memread;
            if (w_insert_nop) begin
                r_ex_valid    <= 1'b0;
                r_ex_rd       <= '0;
                r_ex_regwrite <= 1'b0;
                r_ex_memread  <= 1'b0;
                r_fwd_a       <= SEL_NONE;
                r_fwd_b       <= SEL_NONE;
            end else begin
                r_ex_valid    <= id_valid;
                r_ex_rd       <= id_rd;
                r_ex_regwrite <= id_regwrite;
                r_ex_memread  <= id_memread;
                r_fwd_a       <= w_sel_a;
                r_fwd_b       <= w_sel_b;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_fwd_ctrl.sv
`default_nettype none
//==============================================================================
//  Module   : tb_hazard_fwd_ctrl
//  Purpose  : Scoreboard bench for hazard_fwd_ctrl. A driver issues one
//             instruction per cycle and pushes the reference model's expected
//             outputs; a monitor pops and compares on the falling edge.
//             Works in both builds (FORWARDING_EN defined or not).
//  Revision : 1.0  initial release
//==============================================================================
module tb_hazard_fwd_ctrl;

    localparam int REG_AW = 5;

`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              id_regwrite;
    logic              id_memread;
    logic              ex_flush;
    logic              mem_wait;
    logic [1:0]        forward_A;
    logic [1:0]        forward_B;
    logic              stall;
    logic              id_ex_bubble;
    logic              if_id_flush;

    always #5 clk = ~clk;

    hazard_fwd_ctrl #(.REG_AW(REG_AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_rd        (id_rd),
        .id_regwrite  (id_regwrite),
        .id_memread   (id_memread),
        .ex_flush     (ex_flush),
        .mem_wait     (mem_wait),
        .forward_A    (forward_A),
        .forward_B    (forward_B),
        .stall        (stall),
        .id_ex_bubble (id_ex_bubble),
        .if_id_flush  (if_id_flush)
    );

    //--------------------------------------------------------------------------
    // Reference model: a history of what entered EX (index 0 = in EX now,
    // 1 = in MEM, 2 = in WB) plus the operand selects latched for EX.
    //--------------------------------------------------------------------------
    typedef struct {
        bit v;
        int rd;
        bit wr;
        bit ld;
    } slot_t;

    typedef struct {
        bit stall;
        bit bub;
        bit fl;
        int fa;
        int fb;
    } exp_t;

    slot_t hist[$];
    int    m_fa;
    int    m_fb;
    exp_t  q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    function automatic slot_t empty_slot();
        slot_t s;
        s.v = 0; s.rd = 0; s.wr = 0; s.ld = 0;
        return s;
    endfunction

    task automatic model_reset();
        hist.delete();
        repeat (3) hist.push_back(empty_slot());
        m_fa = 0;
        m_fb = 0;
    endtask

    // Producer in slot s writes the register this source reads.
    function automatic bit src_hit(slot_t s, bit v, int rs, bit u);
        return v && u && s.v && s.wr && (s.rd != 0) && (s.rd == rs);
    endfunction

    function automatic bit load_hit(slot_t s, bit v, int rs, bit u);
        return v && u && s.v && s.ld && (s.rd != 0) && (s.rd == rs);
    endfunction

    function automatic int sel(bit v, int rs, bit u);
        if (src_hit(hist[0], v, rs, u)) return 2;
        if (src_hit(hist[1], v, rs, u)) return 1;
        return 0;
    endfunction

    //--------------------------------------------------------------------------
    // Driver: one call = one clock cycle of stimulus
    //--------------------------------------------------------------------------
    task automatic op(input int v, input int rs1, input int u1, input int rs2,
                      input int u2, input int rd, input int wr, input int ld,
                      input int fl = 0, input int mw = 0, input int rn = 1);
        exp_t  e;
        slot_t ns;
        bit    hz;
        bit    nop;
        int    na;
        int    nb;
        @(posedge clk);
        #1;
        cyc++;
        rst_n       = rn[0];
        id_valid    = v[0];
        id_rs1      = rs1[REG_AW-1:0];
        id_use_rs1  = u1[0];
        id_rs2      = rs2[REG_AW-1:0];
        id_use_rs2  = u2[0];
        id_rd       = rd[REG_AW-1:0];
        id_regwrite = wr[0];
        id_memread  = ld[0];
        ex_flush    = fl[0];
        mem_wait    = mw[0];

        e.stall = 0; e.bub = 0; e.fl = 0; e.fa = 0; e.fb = 0;
        if (rn == 0) begin
            model_reset();
        end else begin
            e.fa = m_fa;
            e.fb = m_fb;
            if (mw != 0) begin
                e.stall = 1;
            end else begin
                if (FWD)
                    hz = load_hit(hist[0], v[0], rs1, u1[0]) ||
                         load_hit(hist[0], v[0], rs2, u2[0]);
                else
                    hz = src_hit(hist[0], v[0], rs1, u1[0]) ||
                         src_hit(hist[0], v[0], rs2, u2[0]) ||
                         src_hit(hist[1], v[0], rs1, u1[0]) ||
                         src_hit(hist[1], v[0], rs2, u2[0]);
                nop     = (fl != 0) || hz;
                e.fl    = (fl != 0);
                e.bub   = nop;
                e.stall = (fl == 0) && hz;
                na = (nop || !FWD) ? 0 : sel(v[0], rs1, u1[0]);
                nb = (nop || !FWD) ? 0 : sel(v[0], rs2, u2[0]);
                if (nop) ns = empty_slot();
                else begin
                    ns.v = v[0]; ns.rd = rd; ns.wr = wr[0]; ns.ld = ld[0];
                end
                hist.push_front(ns);
                void'(hist.pop_back());
                m_fa = na;
                m_fb = nb;
            end
        end
        q.push_back(e);
    endtask

    task automatic nop_op(input int n);
        repeat (n) op(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    endtask

    //--------------------------------------------------------------------------
    // Monitor
    //--------------------------------------------------------------------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("stall",        int'(stall),        int'(e.stall));
                check("id_ex_bubble", int'(id_ex_bubble), int'(e.bub));
                check("if_id_flush",  int'(if_id_flush),  int'(e.fl));
                check("forward_A",    int'(forward_A),    e.fa);
                check("forward_B",    int'(forward_B),    e.fb);
            end
        end
    end

    //--------------------------------------------------------------------------
    // Stimulus
    //--------------------------------------------------------------------------
    initial begin
        rst_n = 0; id_valid = 0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0;
        id_use_rs2 = 0; id_rd = '0; id_regwrite = 0; id_memread = 0;
        ex_flush = 0; mem_wait = 0;
        model_reset();

        // Reset state, with mem_wait and ex_flush driven during reset
        op(1, 5, 1, 5, 1, 5, 1, 1, 1, 1, 0);
        op(1, 5, 1, 5, 1, 5, 1, 1, 0, 1, 0);
        nop_op(1);

        // add x5 ; add rs1=x5 (consumer repeated while IF/ID is held)
        op(1, 1, 1, 2, 1, 5, 1, 0);
        op(1, 5, 1, 3, 1, 6, 1, 0);
        op(1, 5, 1, 3, 1, 6, 1, 0);
        op(1, 5, 1, 3, 1, 6, 1, 0);
        nop_op(3);

        // add x5 ; unrelated ; consumer rs2=x5
        op(1, 1, 1, 2, 1, 5, 1, 0);
        op(1, 1, 1, 2, 1, 9, 1, 0);
        op(1, 3, 1, 5, 1, 6, 1, 0);
        op(1, 3, 1, 5, 1, 6, 1, 0);
        nop_op(3);

        // lw x7 ; consumer rs1=x7
        op(1, 1, 1, 0, 0, 7, 1, 1);
        op(1, 7, 1, 2, 1, 8, 1, 0);
        op(1, 7, 1, 2, 1, 8, 1, 0);
        op(1, 7, 1, 2, 1, 8, 1, 0);
        nop_op(3);

        // writer to x0 ; consumer rs1=x0
        op(1, 1, 1, 2, 1, 0, 1, 0);
        op(1, 0, 1, 0, 1, 4, 1, 0);
        nop_op(2);

        // lw x7 ; consumer rs1=x7 together with ex_flush
        op(1, 1, 1, 0, 0, 7, 1, 1);
        op(1, 7, 1, 2, 1, 8, 1, 0, 1);
        op(1, 7, 1, 2, 1, 8, 1, 0);
        nop_op(3);

        // forwarded consumer frozen for 3 cycles, then reset mid-freeze
        op(1, 1, 1, 2, 1, 5, 1, 0);
        op(1, 5, 1, 5, 1, 6, 1, 0);
        op(1, 6, 1, 5, 1, 7, 1, 0, 0, 1);
        op(1, 6, 1, 5, 1, 7, 1, 0, 0, 1);
        op(1, 6, 1, 5, 1, 7, 1, 0, 0, 1);
        op(1, 6, 1, 5, 1, 7, 1, 0, 0, 0);
        op(1, 1, 1, 2, 1, 5, 1, 0);
        op(1, 5, 1, 5, 1, 6, 1, 0);
        op(1, 6, 1, 5, 1, 7, 1, 0, 0, 1);
        op(1, 6, 1, 5, 1, 7, 1, 0, 0, 1, 0);
        op(1, 6, 1, 5, 1, 7, 1, 0, 0, 0);
        nop_op(2);

        // lw x3 followed by a freeze, then the dependent consumer
        op(1, 1, 1, 0, 0, 3, 1, 1);
        op(1, 3, 1, 3, 1, 4, 1, 0, 0, 1);
        op(1, 3, 1, 3, 1, 4, 1, 0);
        op(1, 3, 1, 3, 1, 4, 1, 0);
        op(1, 3, 1, 3, 1, 4, 1, 0);
        nop_op(2);

        // Randomized traffic on a small register set to force many matches
        for (int i = 0; i < 800; i++) begin
            op(($urandom_range(0, 9) != 0) ? 1 : 0,
               $urandom_range(0, 3), $urandom_range(0, 1),
               $urandom_range(0, 3), $urandom_range(0, 1),
               $urandom_range(0, 3), $urandom_range(0, 1),
               $urandom_range(0, 1),
               ($urandom_range(0, 9) == 0) ? 1 : 0,
               ($urandom_range(0, 6) == 0) ? 1 : 0,
               ($urandom_range(0, 49) == 0) ? 0 : 1);
        end

        repeat (2) @(posedge clk);
        check("scoreboard_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_fwd_ctrl.md
HAZARD_FWD_CTRL -- requirements
Module: hazard_fwd_ctrl

Interface
REQ-001 The block SHALL have the parameter REG_AW, default 5, meaning the register-index width.
REQ-002 The block SHALL have the port clk, input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have the port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-004 The block SHALL have the port id_valid, input, 1 bit, meaning the instruction in ID is real.
REQ-005 The block SHALL have the ports id_rs1 and id_rs2, input, REG_AW bits each, the ID source indices.
REQ-006 The block SHALL have the ports id_use_rs1 and id_use_rs2, input, 1 bit each, meaning the source is actually read.
REQ-007 The block SHALL have the port id_rd, input, REG_AW bits, the ID destination index.
REQ-008 The block SHALL have the ports id_regwrite and id_memread, input, 1 bit each, meaning the ID instruction writes rd or is a load.
REQ-009 The block SHALL have the port ex_flush, input, 1 bit, meaning a taken branch or jump resolved in EX.
REQ-010 The block SHALL have the port mem_wait, input, 1 bit, meaning data memory is busy and the pipeline freezes.
REQ-011 The block SHALL have the ports forward_A and forward_B, output, 2 bits each, the ALU operand selects: 00 normal, 01 mem_result, 10 alu_result.
REQ-012 The block SHALL have the port stall, output, 1 bit, meaning hold the PC and the IF/ID register.
REQ-013 The block SHALL have the port id_ex_bubble, output, 1 bit, meaning load a NOP into ID/EX.
REQ-014 The block SHALL have the port if_id_flush, output, 1 bit, meaning squash the IF/ID contents.

Function
REQ-015 The block SHALL keep three shadow slots, EX, MEM and WB, each holding valid, rd, regwrite and memread, which advance EX to MEM to WB every non-frozen cycle.
REQ-016 A slot SHALL be a forwarding source only if valid=1, regwrite=1 and rd!=0.
REQ-017 The FSM SHALL have the states RUN, LU_STALL and FREEZE, and its reset state SHALL be RUN.
REQ-018 A load-use hazard SHALL exist when id_valid=1, the EX slot is a valid load, and its rd!=0 matches a used id_rs.
REQ-019 In RUN, a load-use hazard with no flush SHALL produce stall=1 and id_ex_bubble=1 combinationally, load an invalid entry into the EX slot, and move the FSM to LU_STALL.
REQ-020 LU_STALL SHALL last exactly one cycle and return to RUN; the load then sits in the MEM slot, so forwarding resolves to 01 with no further stall.
REQ-021 On ex_flush=1 (and mem_wait=0), the block SHALL assert if_id_flush=1 and id_ex_bubble=1, load an invalid EX slot, and keep stall=0.
REQ-022 ex_flush SHALL take priority over a load-use hazard.
REQ-023 When mem_wait=1, the FSM SHALL enter or stay in FREEZE, assert stall=1 with id_ex_bubble=0 and if_id_flush=0, and hold all slots and forward selects unchanged.
REQ-024 mem_wait SHALL take priority over flush and load-use.
REQ-025 FREEZE SHALL exit to RUN on the first cycle with mem_wait=0, re-evaluating the hazards that cycle.
REQ-026 forward_A and forward_B SHALL be registered, loaded when the ID instruction advances into EX, and valid for that instruction's entire EX occupancy.
REQ-027 Select computation for each source: if it matches the current EX slot (next cycle's EX/MEM), the select SHALL be 10; otherwise, if it matches the current MEM slot, 01; otherwise 00. EX match SHALL win over MEM match.
REQ-028 A source with id_use=0 SHALL get select 00.
REQ-029 On a bubble or flush, the loaded selects SHALL be 00.

Reset
REQ-030 While rst_n=0, all slots SHALL be invalid, the state SHALL be RUN, forward_A=forward_B=00, and stall=id_ex_bubble=if_id_flush=0.
REQ-031 Reset asserted mid-stall or mid-freeze SHALL abort it immediately, with no residual bubble after release.

Configuration
REQ-032 With FORWARDING_EN defined, the block SHALL behave as specified above.
REQ-033 With FORWARDING_EN undefined, forward_A and forward_B SHALL be constant 00, and any RAW match against a valid writing EX or MEM slot SHALL stall, inserting bubbles until no match remains: 2 cycles for an EX match, 1 for a MEM match.

Verification
REQ-034 add x5 followed immediately by add using rs1=x5 SHALL produce forward_A=10 during the consumer's EX and no stall.
REQ-035 add x5, then an unrelated instruction, then a consumer with rs2=x5 SHALL produce forward_B=01.
REQ-036 lw x7 followed immediately by a consumer with rs1=x7 SHALL produce exactly one stall/bubble cycle, then forward_A=01.
REQ-037 A writer with rd=x0 followed by a consumer with rs1=x0 SHALL keep forward_A=00 and stall=0.
REQ-038 A load-use pair plus ex_flush in the same cycle SHALL produce if_id_flush=1, stall=0, and no LU_STALL.
REQ-039 mem_wait held for 3 cycles during a forwarded consumer SHALL keep stall=1 and the selects unchanged throughout; rst_n pulsed low mid-freeze SHALL clear all outputs to 0.
